// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared constants for the fetch front end.
//   XLEN_DEFAULT : default PC width in bits
//   INSN_BYTES   : fixed PC increment per granted fetch
//   hart_width() : width of a hart index, never narrower than one bit so a
//                  single-hart build still has a real index signal
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSN_BYTES   = 4;

  function automatic int hart_width(input int num_harts);
    return (num_harts <= 2) ? 1 : $clog2(num_harts);
  endfunction

endpackage

// File: rtl/pc_rr_select.sv
// pc_rr_select
// Picks the next enabled hart after cur in ascending round-robin order,
// wrapping past the top. cur itself is the last candidate, so a lone enabled
// hart keeps selecting itself. With no hart enabled, next holds cur.
// Ports:
//   cur     : current hart pointer
//   hart_en : per-hart run enable
//   next    : selected next hart
module pc_rr_select #(
  parameter int NUM_HARTS = 2,
  parameter int HART_W    = 1
) (
  input  logic [HART_W-1:0]    cur,
  input  logic [NUM_HARTS-1:0] hart_en,
  output logic [HART_W-1:0]    next
);

  int w_dist;
  int w_best;

  // Rank every hart by its round-robin distance after cur (cur itself ranks
  // last) and keep the closest enabled one.
  always_comb begin
    next   = cur;
    w_best = NUM_HARTS;
    w_dist = 0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      w_dist = (i + NUM_HARTS - 1 - int'(cur)) % NUM_HARTS;
      if (hart_en[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        next   = HART_W'(i);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Multi-hart PC sequencer: holds one PC per hart and round-robins fetch
// requests between the enabled harts. Redirects and traps may load any
// hart's PC in the same cycle as the fetch increment of another hart.
// Build option:
//   PC_COMPRESSED_EN : when defined, redirects only need 16-bit alignment;
//                      otherwise they need 32-bit alignment.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   hart_en                     : per-hart run enable
//   fetch_valid/ready/pc/hart   : fetch request handshake
//   redirect_valid/hart/pc      : branch/jump redirect
//   trap_valid/hart/vector      : trap entry (vector low two bits dropped)
//   misalign_fault/hart/pc      : one-cycle report of a rejected redirect
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter int              NUM_HARTS    = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  localparam int             HART_W       = hart_width(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HARTS-1:0] hart_en,
  output logic                 fetch_valid,
  input  logic                 fetch_ready,
  output logic [XLEN-1:0]      fetch_pc,
  output logic [HART_W-1:0]    fetch_hart,
  input  logic                 redirect_valid,
  input  logic [HART_W-1:0]    redirect_hart,
  input  logic [XLEN-1:0]      redirect_pc,
  input  logic                 trap_valid,
  input  logic [HART_W-1:0]    trap_hart,
  input  logic [XLEN-1:0]      trap_vector,
  output logic                 misalign_fault,
  output logic [HART_W-1:0]    misalign_hart,
  output logic [XLEN-1:0]      misalign_pc
);

  logic [XLEN-1:0]   r_pc [NUM_HARTS];
  logic [HART_W-1:0] r_cur;
  logic              r_misalign_fault;
  logic [HART_W-1:0] r_misalign_hart;
  logic [XLEN-1:0]   r_misalign_pc;

  logic [XLEN-1:0]   w_pc_next [NUM_HARTS];
  logic [HART_W-1:0] w_rr_next;
  logic [HART_W-1:0] w_cur_next;
  logic              w_fire;
  logic              w_misaligned;
  logic              w_redirect_hit;
  logic              w_redirect_ok;
  logic              w_redirect_bad;
  logic              w_trap_hit;
  logic [XLEN-1:0]   w_trap_target;

  assign fetch_valid = hart_en[r_cur];
  assign fetch_pc    = r_pc[r_cur];
  assign fetch_hart  = r_cur;
  assign w_fire      = fetch_valid && fetch_ready;

`ifdef PC_COMPRESSED_EN
  assign w_misaligned = redirect_pc[0];
`else
  assign w_misaligned = |redirect_pc[1:0];
`endif

  // Requests naming a hart that does not exist are dropped entirely.
  assign w_redirect_hit = redirect_valid && (int'(redirect_hart) < NUM_HARTS);
  assign w_redirect_ok  = w_redirect_hit && !w_misaligned;
  assign w_redirect_bad = w_redirect_hit && w_misaligned;
  assign w_trap_hit     = trap_valid && (int'(trap_hart) < NUM_HARTS);
  assign w_trap_target  = trap_vector & ~XLEN'(3);

  pc_rr_select #(
    .NUM_HARTS(NUM_HARTS),
    .HART_W   (HART_W)
  ) u_rr_select (
    .cur    (r_cur),
    .hart_en(hart_en),
    .next   (w_rr_next)
  );

  // The pointer moves on a grant or when the current hart is switched off,
  // so a stalled request on an enabled hart keeps its PC and index stable.
  always_comb begin
    w_cur_next = r_cur;
    if (w_fire || !hart_en[r_cur]) begin
      w_cur_next = w_rr_next;
    end
  end

  // Per-hart PC update, later assignments win: increment, then redirect,
  // then trap.
  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      w_pc_next[i] = r_pc[i];
      if (w_fire && (r_cur == HART_W'(i))) begin
        w_pc_next[i] = r_pc[i] + XLEN'(INSN_BYTES);
      end
      if (w_redirect_ok && (redirect_hart == HART_W'(i))) begin
        w_pc_next[i] = redirect_pc;
      end
      if (w_trap_hit && (trap_hart == HART_W'(i))) begin
        w_pc_next[i] = w_trap_target;
      end
    end
  end

  // State registers; the fault flag is rewritten every cycle so it pulses
  // once per rejected redirect, while the captured hart/pc persist.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        r_pc[i] <= RESET_VECTOR;
      end
      r_cur            <= '0;
      r_misalign_fault <= 1'b0;
      r_misalign_hart  <= '0;
      r_misalign_pc    <= '0;
    end else begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        r_pc[i] <= w_pc_next[i];
      end
      r_cur            <= w_cur_next;
      r_misalign_fault <= w_redirect_bad;
      if (w_redirect_bad) begin
        r_misalign_hart <= redirect_hart;
        r_misalign_pc   <= redirect_pc;
      end
    end
  end

  assign misalign_fault = r_misalign_fault;
  assign misalign_hart  = r_misalign_hart;
  assign misalign_pc    = r_misalign_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer (XLEN=32, two harts, reset vector 0).
// Expected fetch grants and misalign reports are queued by the stimulus and
// consumed by a monitor; held-state expectations are checked directly.
module tb_pc_sequencer;

  localparam int XLEN   = 32;
  localparam int HART_W = 1;

`ifdef PC_COMPRESSED_EN
  localparam logic [31:0] PC1_AFTER_F = 32'h102;
`else
  localparam logic [31:0] PC1_AFTER_F = 32'h400;
`endif

  typedef struct packed {
    logic [HART_W-1:0] hart;
    logic [XLEN-1:0]   pc;
  } expEntry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        hart_en;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [XLEN-1:0]   fetch_pc;
  logic [HART_W-1:0] fetch_hart;
  logic              redirect_valid;
  logic [HART_W-1:0] redirect_hart;
  logic [XLEN-1:0]   redirect_pc;
  logic              trap_valid;
  logic [HART_W-1:0] trap_hart;
  logic [XLEN-1:0]   trap_vector;
  logic              misalign_fault;
  logic [HART_W-1:0] misalign_hart;
  logic [XLEN-1:0]   misalign_pc;

  expEntry_t fetchQ[$];
  expEntry_t faultQ[$];
  int checks   = 0;
  int failures = 0;

  pc_sequencer #(
    .XLEN        (32),
    .NUM_HARTS   (2),
    .RESET_VECTOR(32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hart_en       (hart_en),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_pc      (fetch_pc),
    .fetch_hart    (fetch_hart),
    .redirect_valid(redirect_valid),
    .redirect_hart (redirect_hart),
    .redirect_pc   (redirect_pc),
    .trap_valid    (trap_valid),
    .trap_hart     (trap_hart),
    .trap_vector   (trap_vector),
    .misalign_fault(misalign_fault),
    .misalign_hart (misalign_hart),
    .misalign_pc   (misalign_pc)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic compareVal(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pushFetch(input logic [HART_W-1:0] h, input logic [XLEN-1:0] p);
    expEntry_t e;
    e.hart = h;
    e.pc   = p;
    fetchQ.push_back(e);
  endtask

  task automatic pushFault(input logic [HART_W-1:0] h, input logic [XLEN-1:0] p);
    expEntry_t e;
    e.hart = h;
    e.pc   = p;
    faultQ.push_back(e);
  endtask

  // Advance the given number of rising edges, leaving time just after an edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sample the fetch outputs mid-cycle, then step one edge.
  task automatic checkOutput(input string name, input logic [XLEN-1:0] expPc,
                             input logic [HART_W-1:0] expHart, input logic expValid);
    @(negedge clk);
    compareVal({name, "_pc"}, fetch_pc, expPc);
    compareVal({name, "_hart"}, fetch_hart, expHart);
    compareVal({name, "_valid"}, fetch_valid, expValid);
    @(posedge clk);
    #1;
  endtask

  task automatic clearSideInputs();
    redirect_valid = 1'b0;
    redirect_hart  = '0;
    redirect_pc    = '0;
    trap_valid     = 1'b0;
    trap_hart      = '0;
    trap_vector    = '0;
  endtask

  // Monitor: every accepted fetch and every fault pulse must match the head
  // of its expectation queue; anything unexpected counts as a failure.
  always @(negedge clk) begin
    expEntry_t e;
    if (!rst && fetch_valid && fetch_ready) begin
      if (fetchQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL fetch_unexpected actual_hart=%0d actual_pc=%0h required=none", fetch_hart, fetch_pc);
      end else begin
        e = fetchQ.pop_front();
        compareVal("grant_hart", fetch_hart, e.hart);
        compareVal("grant_pc", fetch_pc, e.pc);
      end
    end
    if (!rst && misalign_fault) begin
      if (faultQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL fault_unexpected actual_hart=%0d actual_pc=%0h required=none", misalign_hart, misalign_pc);
      end else begin
        e = faultQ.pop_front();
        compareVal("fault_hart", misalign_hart, e.hart);
        compareVal("fault_pc", misalign_pc, e.pc);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    rst         = 1'b1;
    hart_en     = 2'b01;
    fetch_ready = 1'b0;
    clearSideInputs();
    applyStimulus(3);
    checkOutput("in_reset", 32'h0, 1'b0, 1'b1);
    compareVal("reset_fault", misalign_fault, 1'b0);

    // First cycle out of reset
    rst = 1'b0;
    checkOutput("post_reset", 32'h0, 1'b0, 1'b1);

    // Single hart streaming
    fetch_ready = 1'b1;
    pushFetch(1'b0, 32'h0);
    pushFetch(1'b0, 32'h4);
    pushFetch(1'b0, 32'h8);
    applyStimulus(3);
    fetch_ready = 1'b0;

    // Two harts alternate
    hart_en     = 2'b11;
    fetch_ready = 1'b1;
    pushFetch(1'b0, 32'hC);
    pushFetch(1'b1, 32'h0);
    pushFetch(1'b0, 32'h10);
    pushFetch(1'b1, 32'h4);
    applyStimulus(4);
    fetch_ready = 1'b0;

    // Stall holds, then redirect of the current hart
    checkOutput("stall_0", 32'h14, 1'b0, 1'b1);
    checkOutput("stall_1", 32'h14, 1'b0, 1'b1);
    checkOutput("stall_2", 32'h14, 1'b0, 1'b1);
    redirect_valid = 1'b1;
    redirect_hart  = 1'b0;
    redirect_pc    = 32'h100;
    applyStimulus(1);
    clearSideInputs();
    checkOutput("redirect_cur", 32'h100, 1'b0, 1'b1);
    fetch_ready = 1'b1;
    pushFetch(1'b0, 32'h100);
    applyStimulus(1);
    fetch_ready = 1'b0;

    // Trap beats redirect on hart 0 while hart 1 is granted
    fetch_ready    = 1'b1;
    trap_valid     = 1'b1;
    trap_hart      = 1'b0;
    trap_vector    = 32'h203;
    redirect_valid = 1'b1;
    redirect_hart  = 1'b0;
    redirect_pc    = 32'h80;
    pushFetch(1'b1, 32'h8);
    applyStimulus(1);
    clearSideInputs();
    fetch_ready = 1'b0;
    checkOutput("trap_over_redirect", 32'h200, 1'b0, 1'b1);

    // Redirect of hart 1 alongside a grant on hart 0
    fetch_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_hart  = 1'b1;
    redirect_pc    = 32'h300;
    pushFetch(1'b0, 32'h200);
    applyStimulus(1);
    clearSideInputs();
    fetch_ready = 1'b0;
    checkOutput("parallel_redirect", 32'h300, 1'b1, 1'b1);

    // Trap still lands when the same-cycle redirect is rejected
    redirect_valid = 1'b1;
    redirect_hart  = 1'b1;
    redirect_pc    = 32'h502;
    trap_valid     = 1'b1;
    trap_hart      = 1'b1;
    trap_vector    = 32'h400;
`ifndef PC_COMPRESSED_EN
    pushFault(1'b1, 32'h502);
`endif
    applyStimulus(1);
    clearSideInputs();
    checkOutput("trap_beats_misalign", 32'h400, 1'b1, 1'b1);

    // Halfword-aligned redirect of the current hart
    redirect_valid = 1'b1;
    redirect_hart  = 1'b1;
    redirect_pc    = 32'h102;
`ifndef PC_COMPRESSED_EN
    pushFault(1'b1, 32'h102);
`endif
    applyStimulus(1);
    clearSideInputs();
    checkOutput("misalign_102", PC1_AFTER_F, 1'b1, 1'b1);

    // Odd redirect is rejected in every build
    redirect_valid = 1'b1;
    redirect_hart  = 1'b0;
    redirect_pc    = 32'h101;
    pushFault(1'b0, 32'h101);
    applyStimulus(1);
    clearSideInputs();
    checkOutput("misalign_101", PC1_AFTER_F, 1'b1, 1'b1);

    // Disabled current hart is skipped; no enabled hart holds the pointer
    hart_en = 2'b01;
    checkOutput("disabled_cur", PC1_AFTER_F, 1'b1, 1'b0);
    checkOutput("skip_to_0", 32'h204, 1'b0, 1'b1);
    hart_en = 2'b00;
    checkOutput("none_en_a", 32'h204, 1'b0, 1'b0);
    checkOutput("none_en_b", 32'h204, 1'b0, 1'b0);

    // PC wrap at the top of the address space
    hart_en        = 2'b11;
    redirect_valid = 1'b1;
    redirect_hart  = 1'b0;
    redirect_pc    = 32'hFFFF_FFFC;
    applyStimulus(1);
    clearSideInputs();
    checkOutput("pre_wrap", 32'hFFFF_FFFC, 1'b0, 1'b1);
    fetch_ready = 1'b1;
    pushFetch(1'b0, 32'hFFFF_FFFC);
    pushFetch(1'b1, PC1_AFTER_F);
    pushFetch(1'b0, 32'h0);
    applyStimulus(3);

    // Reset in the middle of streaming
    rst = 1'b1;
    applyStimulus(2);
    compareVal("mid_rst_fault", misalign_fault, 1'b0);
    compareVal("mid_rst_fault_hart", misalign_hart, 1'b0);
    compareVal("mid_rst_fault_pc", misalign_pc, 32'h0);
    rst = 1'b0;
    pushFetch(1'b0, 32'h0);
    pushFetch(1'b1, 32'h0);
    applyStimulus(2);
    fetch_ready = 1'b0;
    checkOutput("post_mid_reset", 32'h4, 1'b0, 1'b1);

    applyStimulus(2);
    compareVal("fetch_queue_empty", 64'(fetchQ.size()), 64'd0);
    compareVal("fault_queue_empty", 64'(faultQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL accept parameter XLEN, default 32, giving the PC width in bits.
REQ-002 The module SHALL accept parameter NUM_HARTS, default 2, giving the number of hart PCs held (legal range 1..8).
REQ-003 The module SHALL accept parameter RESET_VECTOR, default 0, giving the XLEN-bit PC value loaded on reset.
REQ-004 The module SHALL derive HART_W = max(1, clog2(NUM_HARTS)) and expose no other parameters.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 hart_en  in  NUM_HARTS  per-hart run enable.
REQ-008 fetch_valid  out  1  fetch_pc/fetch_hart carry a valid request.
REQ-009 fetch_ready  in  1  fetch stage accepts the request.
REQ-010 fetch_pc  out  XLEN  PC of the selected hart.
REQ-011 fetch_hart  out  HART_W  index of the selected hart.
REQ-012 redirect_valid, redirect_hart, redirect_pc  in  1/HART_W/XLEN  branch/jump redirect.
REQ-013 trap_valid, trap_hart, trap_vector  in  1/HART_W/XLEN  trap entry.
REQ-014 misalign_fault, misalign_hart, misalign_pc  out  1/HART_W/XLEN  rejected-redirect report.

Function
REQ-015 The module SHALL hold one XLEN-bit PC register per hart and one HART_W-bit current-hart pointer cur.
REQ-016 fetch_pc SHALL equal pc[cur], fetch_hart SHALL equal cur, and fetch_valid SHALL equal hart_en[cur], all combinational from registers and hart_en.
REQ-017 On a handshake (fetch_valid && fetch_ready), pc[cur] SHALL become pc[cur]+4 modulo 2^XLEN (all-ones-minus-3 wraps to 0).
REQ-018 On a handshake, or whenever hart_en[cur]=0, cur SHALL advance to the next enabled hart after cur in ascending round-robin order, wrapping; if no hart is enabled, cur SHALL hold.
REQ-019 While fetch_valid && !fetch_ready, fetch_pc and fetch_hart SHALL stay stable unless a redirect or trap targets hart cur.
REQ-020 A legal redirect SHALL load pc[redirect_hart] <= redirect_pc on the next edge, overriding the +4 increment when redirect_hart==cur.
REQ-021 A trap SHALL load pc[trap_hart] <= {trap_vector[XLEN-1:2],2'b00}, overriding both redirect and increment for that hart.
REQ-022 Redirect, trap and increment targeting different harts SHALL all take effect in the same cycle.
REQ-023 A misaligned redirect SHALL leave the PC unchanged and SHALL assert misalign_fault for exactly one cycle on the next edge, with misalign_hart/misalign_pc capturing the request; a same-cycle trap to that hart still applies.
REQ-024 redirect_hart or trap_hart >= NUM_HARTS SHALL be ignored.

Reset
REQ-025 On rst, every pc[i] SHALL load RESET_VECTOR, cur SHALL load 0, and misalign_fault, misalign_hart and misalign_pc SHALL load 0; rst overrides all other inputs, including in-flight handshakes.
REQ-026 After reset deasserts, fetch_pc SHALL be RESET_VECTOR and fetch_valid SHALL equal hart_en[0] in the first cycle.

Configuration
REQ-027 With macro PC_COMPRESSED_EN defined, a redirect SHALL be misaligned only when redirect_pc[0]=1 (16-bit IALIGN).
REQ-028 Without PC_COMPRESSED_EN, a redirect SHALL be misaligned when redirect_pc[1:0]!=0 (32-bit IALIGN); the increment is +4 in both builds.

Structure
REQ-029 XLEN default, the instruction size constant 4, and HART_W derivation SHALL live in shared package riscv_pkg.
REQ-030 Round-robin next-enabled-hart selection SHALL be a sub-module pc_rr_select (inputs: cur, hart_en; output: next).

Verification
REQ-031 Reset, then hart_en=2'b01 and fetch_ready=1 for 3 cycles -> fetch_pc sequence 0x0, 0x4, 0x8 with fetch_hart=0.
REQ-032 hart_en=2'b11, fetch_ready=1 -> fetch_hart alternates 0,1,0,1 and each hart's PC advances by 4 only on its own grants.
REQ-033 fetch_ready=0 for 3 cycles -> fetch_pc/fetch_hart held; redirect hart cur to 0x100 -> fetch_pc=0x100 on the next cycle.
REQ-034 Same cycle: trap hart 0 to 0x203 and redirect hart 0 to 0x80 -> pc[0]=0x200.
REQ-035 Redirect to 0x102 -> without PC_COMPRESSED_EN, one-cycle misalign_fault with pc=0x102 and the PC unchanged; with the macro, pc=0x102 and no fault.
REQ-036 pc=0xFFFFFFFC with a handshake -> pc=0x0; rst asserted mid-stream -> all PCs at RESET_VECTOR and cur=0.
